// File: rtl/sram_match_scheduler.sv
// sram_match_scheduler: sweeps port matchers over SRAM banks, arbitrates claims, owns table.
// Define SCHED_RR_ARB_EN for round-robin claim arbitration (default: lowest port wins).
module sram_match_scheduler #(
  parameter int NUM_PORTS    = 16,
  parameter int NUM_SRAM     = 32,
  parameter int SWEEP_STRIDE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   match_enable,
  input  logic [NUM_PORTS-1:0]   match_suc,
  input  logic [6*NUM_PORTS-1:0] match_best_sram,
  input  logic [NUM_PORTS-1:0]   release_req,
  output logic [5*NUM_PORTS-1:0] match_sram,
  output logic [NUM_PORTS-1:0]   accessible,
  output logic [NUM_PORTS-1:0]   bind_valid,
  output logic [NUM_PORTS-1:0]   bind_fail,
  output logic [5*NUM_PORTS-1:0] bind_sram,
  output logic [NUM_PORTS-1:0]   own_valid,
  output logic [NUM_SRAM-1:0]    sram_busy
);

  localparam int PW = 4;
  localparam int BW = 5;

  logic [BW-1:0]        offset;
  logic [BW-1:0]        cand [NUM_PORTS];
  logic [5:0]           best [NUM_PORTS];
  logic [PW-1:0]        owner [NUM_SRAM];
  logic [NUM_PORTS-1:0] req [NUM_SRAM];
  logic [NUM_PORTS-1:0] claim;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] fail;
  logic [NUM_PORTS-1:0] rel_hit;
  logic [NUM_SRAM-1:0]  rel_mask;
  logic [NUM_SRAM-1:0]  grant_mask;
  logic                 found;
  logic [PW-1:0]        idx;
  logic [PW-1:0]        win;

`ifdef SCHED_RR_ARB_EN
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_nxt;
`endif

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cand[p] = offset + BW'(SWEEP_STRIDE * p);
      best[p] = match_best_sram[6*p +: 6];
    end
  end

  // A claim is only eligible against table state from before this cycle.
  always_comb begin
    claim = match_enable & match_suc;
    for (int b = 0; b < NUM_SRAM; b++) begin
      req[b] = '0;
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (claim[p] && best[p] < 6'(NUM_SRAM) &&
          !own_valid[p] && !sram_busy[best[p][4:0]]) begin
        req[best[p][4:0]][p] = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    win   = '0;
`ifdef SCHED_RR_ARB_EN
    rr_nxt = rr_ptr;
`endif
    for (int b = NUM_SRAM - 1; b >= 0; b--) begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef SCHED_RR_ARB_EN
        idx = rr_ptr + PW'(i);
`else
        idx = PW'(i);
`endif
        if (!found && req[b][idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
      if (found) begin
        grant[win] = 1'b1;
`ifdef SCHED_RR_ARB_EN
        if ($countones(req[b]) > 1) begin
          rr_nxt = win + 1'b1;
        end
`endif
      end
    end
    fail = claim & ~grant;
  end

  always_comb begin
    rel_hit    = release_req & own_valid;
    rel_mask   = '0;
    grant_mask = '0;
    for (int b = 0; b < NUM_SRAM; b++) begin
      rel_mask[b] = sram_busy[b] & release_req[owner[b]];
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        grant_mask[best[p][4:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset     <= '0;
      accessible <= '0;
      bind_valid <= '0;
      bind_fail  <= '0;
      bind_sram  <= '0;
      own_valid  <= '0;
      sram_busy  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        match_sram[BW*p +: BW] <= BW'(SWEEP_STRIDE * p);
      end
      for (int b = 0; b < NUM_SRAM; b++) begin
        owner[b] <= '0;
      end
    end else begin
      offset     <= offset + 1'b1;
      bind_valid <= grant;
      bind_fail  <= fail;
      own_valid  <= (own_valid & ~rel_hit) | grant;
      sram_busy  <= (sram_busy & ~rel_mask) | grant_mask;
      for (int p = 0; p < NUM_PORTS; p++) begin
        match_sram[BW*p +: BW] <= cand[p];
        accessible[p]          <= ~sram_busy[cand[p]];
        if (grant[p]) begin
          bind_sram[BW*p +: BW]  <= best[p][4:0];
          owner[best[p][4:0]]    <= PW'(p);
        end
      end
    end
  end

`ifdef SCHED_RR_ARB_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sram_match_scheduler.sv
// tb_sram_match_scheduler: directed vector table plus reset and sweep sequences.
// Every-cycle monitor checks sweep, accessible and ownership invariants.
module tb_sram_match_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] match_enable = '0;
  logic [15:0] match_suc = '0;
  logic [95:0] match_best_sram = '0;
  logic [15:0] rel = '0;
  logic [79:0] match_sram;
  logic [15:0] accessible;
  logic [15:0] bind_valid;
  logic [15:0] bind_fail;
  logic [79:0] bind_sram;
  logic [15:0] own_valid;
  logic [31:0] sram_busy;

  int checks = 0;
  int failures = 0;
  int n = 0;
  logic [31:0] mdl_busy = '0;
  logic [31:0] prev_busy = '0;

  sram_match_scheduler dut (
    .clk(clk), .rst(rst),
    .match_enable(match_enable), .match_suc(match_suc),
    .match_best_sram(match_best_sram), .release_req(rel),
    .match_sram(match_sram), .accessible(accessible),
    .bind_valid(bind_valid), .bind_fail(bind_fail),
    .bind_sram(bind_sram), .own_valid(own_valid),
    .sram_busy(sram_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] en, suc, rl;
    logic [95:0] best;
    logic [15:0] bv, bf, own;
    logic [31:0] busy;
    int cp, cb;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] bst(input int p0, input int b0,
                                      input int p1, input int b1);
    logic [95:0] r;
    for (int p = 0; p < 16; p++) r[6*p +: 6] = 6'd32;
    if (p0 >= 0) r[6*p0 +: 6] = 6'(b0);
    if (p1 >= 0) r[6*p1 +: 6] = 6'(b1);
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] en, suc, rl,
                              input logic [95:0] best,
                              input logic [15:0] bv, bf, own,
                              input logic [31:0] busy, input int cp, cb);
    vec_t v;
    v.en = en; v.suc = suc; v.rl = rl; v.best = best;
    v.bv = bv; v.bf = bf; v.own = own; v.busy = busy;
    v.cp = cp; v.cb = cb;
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else n <= n + 1;
  end

  always @(negedge clk) begin
    logic [79:0] exp_ms;
    logic [15:0] exp_acc;
    logic ok;
    int cnt_b, cnt_o;
    for (int p = 0; p < 16; p++) begin
      exp_ms[5*p +: 5] = 5'((n == 0 ? 0 : n - 1) + 2 * p);
      exp_acc[p] = (n == 0) ? 1'b0 : ~prev_busy[exp_ms[5*p +: 5]];
    end
    chk("sweep", 128'(match_sram), 128'(exp_ms));
    chk("accessible", 128'(accessible), 128'(exp_acc));
    ok = 1'b1;
    cnt_b = $countones(sram_busy);
    cnt_o = $countones(own_valid);
    if (cnt_b != cnt_o) ok = 1'b0;
    for (int p = 0; p < 16; p++) begin
      if (own_valid[p]) begin
        if (!sram_busy[bind_sram[5*p +: 5]]) ok = 1'b0;
        for (int q = p + 1; q < 16; q++)
          if (own_valid[q] && bind_sram[5*q +: 5] == bind_sram[5*p +: 5])
            ok = 1'b0;
      end
    end
    chk("invariant", 128'(ok), 128'(1'b1));
    prev_busy = mdl_busy;
  end

  task automatic apply(input vec_t v, input string nm);
    match_enable = v.en;
    match_suc = v.suc;
    rel = v.rl;
    match_best_sram = v.best;
    @(posedge clk);
    #1;
    mdl_busy = v.busy;
    chk({nm, ".bind_valid"}, 128'(bind_valid), 128'(v.bv));
    chk({nm, ".bind_fail"}, 128'(bind_fail), 128'(v.bf));
    chk({nm, ".own_valid"}, 128'(own_valid), 128'(v.own));
    chk({nm, ".sram_busy"}, 128'(sram_busy), 128'(v.busy));
    if (v.cp >= 0)
      chk({nm, ".bind_sram"}, 128'(bind_sram[5*v.cp +: 5]), 128'(v.cb));
    match_enable = '0;
    match_suc = '0;
    rel = '0;
    match_best_sram = bst(-1, 0, -1, 0);
  endtask

  initial begin
    vec_t idle;
    logic [79:0] exp_ms;
    idle = mk(0, 0, 0, bst(-1, 0, -1, 0), 0, 0, 0, 0, -1, 0);
    vt[0]  = mk(16'h0008, 16'h0008, 0, bst(3, 7, -1, 0),
                16'h0008, 0, 16'h0008, 32'h80, 3, 7);
    vt[1]  = mk(0, 0, 0, bst(-1, 0, -1, 0), 0, 0, 16'h0008, 32'h80, 3, 7);
    vt[2]  = mk(16'h0204, 16'h0204, 0, bst(2, 20, 9, 20),
                16'h0004, 16'h0200, 16'h000C, 32'h0010_0080, 2, 20);
    vt[3]  = mk(0, 0, 16'h0004, bst(-1, 0, -1, 0),
                0, 0, 16'h0008, 32'h80, 2, 20);
`ifdef SCHED_RR_ARB_EN
    vt[4]  = mk(16'h0204, 16'h0204, 0, bst(2, 20, 9, 20),
                16'h0200, 16'h0004, 16'h0208, 32'h0010_0080, 9, 20);
`else
    vt[4]  = mk(16'h0204, 16'h0204, 0, bst(2, 20, 9, 20),
                16'h0004, 16'h0200, 16'h000C, 32'h0010_0080, 2, 20);
`endif
    vt[5]  = mk(0, 0, 16'h0204, bst(-1, 0, -1, 0),
                0, 0, 16'h0008, 32'h80, -1, 0);
    vt[6]  = mk(16'h0010, 16'h0010, 0, bst(4, 5, -1, 0),
                16'h0010, 0, 16'h0018, 32'hA0, 4, 5);
    vt[7]  = mk(16'h0040, 16'h0040, 16'h0010, bst(6, 5, -1, 0),
                0, 16'h0040, 16'h0008, 32'h80, 4, 5);
    vt[8]  = mk(16'h0040, 16'h0040, 0, bst(6, 5, -1, 0),
                16'h0040, 0, 16'h0048, 32'hA0, 6, 5);
    vt[9]  = mk(16'h0002, 16'h0002, 0, bst(1, 32, -1, 0),
                0, 16'h0002, 16'h0048, 32'hA0, -1, 0);
    vt[10] = mk(16'h0002, 16'h0002, 0, bst(1, 0, -1, 0),
                16'h0002, 0, 16'h004A, 32'hA1, 1, 0);
    vt[11] = mk(16'h0002, 16'h0002, 0, bst(1, 9, -1, 0),
                0, 16'h0002, 16'h004A, 32'hA1, 1, 0);
    vt[12] = mk(0, 16'h0001, 0, bst(0, 9, -1, 0),
                0, 0, 16'h004A, 32'hA1, -1, 0);
    vt[13] = mk(16'h0001, 16'h0001, 0, bst(0, 40, -1, 0),
                0, 16'h0001, 16'h004A, 32'hA1, -1, 0);
    vt[14] = mk(16'h0001, 16'h0001, 0, bst(0, 7, -1, 0),
                0, 16'h0001, 16'h004A, 32'hA1, -1, 0);
    vt[15] = mk(16'h0008, 16'h0008, 16'h0008, bst(3, 12, -1, 0),
                0, 16'h0008, 16'h0042, 32'h21, 3, 7);
    vt[16] = mk(0, 0, 16'h0020, bst(-1, 0, -1, 0),
                0, 0, 16'h0042, 32'h21, -1, 0);
    vt[17] = mk(16'h0500, 16'h0500, 0, bst(8, 12, 10, 30),
                16'h0500, 0, 16'h0542, 32'h4000_1021, 10, 30);
    vt[18] = mk(0, 0, 0, bst(-1, 0, -1, 0),
                0, 0, 16'h0542, 32'h4000_1021, 8, 12);

    match_best_sram = bst(-1, 0, -1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) apply(idle, "idle");
    chk("ms0_after3", 128'(match_sram[4:0]), 128'(5'd2));
    chk("ms5_after3", 128'(match_sram[29:25]), 128'(5'd12));
    chk("ms15_after3", 128'(match_sram[79:75]), 128'(5'd0));
    chk("acc_after3", 128'(accessible), 128'(16'hFFFF));

    for (int i = 0; i < 19; i++) apply(vt[i], $sformatf("vec%0d", i));

    rst = 1'b1;
    mdl_busy = '0;
    #1;
    for (int p = 0; p < 16; p++) exp_ms[5*p +: 5] = 5'(2 * p);
    chk("rst.sram_busy", 128'(sram_busy), 128'(0));
    chk("rst.own_valid", 128'(own_valid), 128'(0));
    chk("rst.bind_valid", 128'(bind_valid), 128'(0));
    chk("rst.bind_fail", 128'(bind_fail), 128'(0));
    chk("rst.accessible", 128'(accessible), 128'(0));
    chk("rst.match_sram", 128'(match_sram), 128'(exp_ms));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) apply(idle, "post_rst");
    apply(mk(16'h0020, 16'h0020, 0, bst(5, 31, -1, 0),
             16'h0020, 0, 16'h0020, 32'h8000_0000, 5, 31), "post_rst_claim");
    apply(mk(0, 0, 0, bst(-1, 0, -1, 0),
             0, 0, 16'h0020, 32'h8000_0000, 5, 31), "post_rst_hold");
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
